// File: rtl/sparrow_dmem_uart_tx.sv
// rtl/sparrow_dmem_uart_tx.sv - dmem-mapped 8N1 UART transmitter with TX FIFO
module sparrow_dmem_uart_tx #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [15:0] RESET_BAUD_DIV = 16'd868
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_dmem_req,
    input  logic [31:0] i_dmem_addr,
    input  logic [1:0]  i_dmem_byte_en,
    input  logic        i_dmem_wr_en,
    input  logic [31:0] i_dmem_wr_data,
    output logic [31:0] o_dmem_rd_data,
    output logic        o_uart_tx,
    output logic        o_irq
);
    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   DEPTH_L = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_q, div_d;
    logic [15:0] baud_div_q, baud_div_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d;
    logic [PW:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]  mem_q [FIFO_DEPTH];

    logic        sel, wr_sel, push_req, push, pop, full, empty, busy, tick, start_ok;
    logic [1:0]  idx;
    logic [PW:0] level;
    logic [15:0] eff_div;
    logic        unused_bits;

    assign unused_bits = ^{i_dmem_byte_en, i_dmem_addr[1:0], i_dmem_wr_data[31:16]};

    assign sel      = i_dmem_req && (i_dmem_addr[31:4] == BASE_ADDR[31:4]);
    assign idx      = i_dmem_addr[3:2];
    assign wr_sel   = sel && i_dmem_wr_en;
    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = (level == DEPTH_L);
    assign empty    = (level == '0);
    assign busy     = (state_q != S_IDLE);
    assign push_req = wr_sel && (idx == 2'd0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push     = push_req && (!full || pop);
    assign eff_div  = (baud_div_q == 16'd0) ? 16'd1 : baud_div_q;
    assign tick     = (baud_cnt_q == div_q - 16'd1);
    assign start_ok = ctrl_q[0] && !empty;
    assign o_irq    = ctrl_q[1] && empty && !busy;

    always_comb begin
        o_dmem_rd_data = 32'd0;
        if (sel) begin
            case (idx)
                2'd1:    o_dmem_rd_data = {16'd0, 8'(level), 4'd0, ovf_q, busy, empty, full};
                2'd2:    o_dmem_rd_data = {16'd0, baud_div_q};
                2'd3:    o_dmem_rd_data = {30'd0, ctrl_q};
                default: o_dmem_rd_data = 32'd0;
            endcase
        end
    end

    always_comb begin
        baud_div_d = baud_div_q;
        ctrl_d     = ctrl_q;
        ovf_d      = ovf_q;
        if (wr_sel && idx == 2'd2) baud_div_d = i_dmem_wr_data[15:0];
        if (wr_sel && idx == 2'd3) ctrl_d = i_dmem_wr_data[1:0];
        if (push_req && full && !pop) ovf_d = 1'b1;
        else if (wr_sel && idx == 2'd1 && i_dmem_wr_data[3]) ovf_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            div_q      <= 16'd1;
            baud_div_q <= RESET_BAUD_DIV;
            ctrl_q     <= 2'd0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            baud_div_q <= baud_div_d;
            ctrl_q     <= ctrl_d;
            ovf_q      <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= i_dmem_wr_data[7:0];
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        div_d      = div_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: baud_cnt_d = 16'd0;
            S_START: if (tick) begin
                baud_cnt_d = 16'd0;
                state_d    = S_DATA;
            end
            S_DATA: if (tick) begin
                baud_cnt_d = 16'd0;
                shift_d    = {1'b0, shift_q[7:1]};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = S_STOP;
            end
            S_STOP: if (tick) begin
                baud_cnt_d = 16'd0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Frame launch shared by IDLE and the end of STOP so back-to-back frames have no gap.
        if (start_ok && (state_q == S_IDLE || (state_q == S_STOP && tick))) begin
            pop        = 1'b1;
            state_d    = S_START;
            shift_d    = mem_q[rd_ptr_q[PW-1:0]];
            div_d      = eff_div;
            baud_cnt_d = 16'd0;
            bit_cnt_d  = 3'd0;
        end
    end

    always_comb begin
        case (state_q)
            S_START: o_uart_tx = 1'b0;
            S_DATA:  o_uart_tx = shift_q[0];
            default: o_uart_tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_sparrow_dmem_uart_tx.sv
// tb/tb_sparrow_dmem_uart_tx.sv - directed self-checking bench for sparrow_dmem_uart_tx
module tb_sparrow_dmem_uart_tx;
    localparam logic [31:0] A_TX = 32'h8000_0000;
    localparam logic [31:0] A_ST = 32'h8000_0004;
    localparam logic [31:0] A_BD = 32'h8000_0008;
    localparam logic [31:0] A_CT = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [1:0]  be = 2'd3;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        tx, irq;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    sparrow_dmem_uart_tx dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_dmem_req(req), .i_dmem_addr(addr),
        .i_dmem_byte_en(be), .i_dmem_wr_en(we), .i_dmem_wr_data(wdata),
        .o_dmem_rd_data(rdata), .o_uart_tx(tx), .o_irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        req = 1'b0;
    endtask

    task automatic rx_frame(input int d, output logic [7:0] b, output int t0,
                            output bit good, output bit busy_all);
        logic [31:0] s;
        b = 8'd0; t0 = 0; good = 1'b0; busy_all = 1'b1;
        for (int w = 0; w < 3000 && tx !== 1'b0; w++) @(negedge clk);
        if (tx !== 1'b0) return;
        good = 1'b1;
        t0 = cyc;
        for (int bi = 0; bi < 10; bi++) begin
            for (int j = 0; j < d; j++) begin
                if (bi == 0) begin
                    if (tx !== 1'b0) good = 1'b0;
                end else if (bi <= 8) begin
                    if (j == 0) b[bi-1] = tx;
                    else if (tx !== b[bi-1]) good = 1'b0;
                end else if (tx !== 1'b1) good = 1'b0;
                rd(A_ST, s);
                if (s[2] !== 1'b1) busy_all = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_start(output bit seen);
        for (int w = 0; w < 3000 && tx !== 1'b0; w++) @(negedge clk);
        seen = (tx === 1'b0);
        n_assert++;
        if (!seen) begin n_fail++; $display("FAIL wait_start: no start bit within bound"); end
    endtask

    task automatic test_reset();
        logic [31:0] s;
        repeat (2) @(negedge clk);
        n_assert++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx); end
        n_assert++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq); end
        n_assert++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        rd(A_ST, s);
        n_assert++; if (s !== 32'h2) begin n_fail++; $display("FAIL rst_status: got %h want 00000002", s); end
        rd(A_BD, s);
        n_assert++; if (s !== 32'd868) begin n_fail++; $display("FAIL rst_baud: got %0d want 868", s); end
        rd(A_CT, s);
        n_assert++; if (s !== 32'd0) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0", s); end
    endtask

    task automatic test_single_frame();
        logic [31:0] s; logic [7:0] b; int t0; bit good, busy_all;
        wr(A_BD, 32'd4);
        wr(A_CT, 32'd1);
        wr(A_TX, 32'hA5);
        rx_frame(4, b, t0, good, busy_all);
        n_assert++; if (!good || b !== 8'hA5) begin n_fail++; $display("FAIL frame_a5: got %h good=%0d want a5", b, good); end
        n_assert++; if (!busy_all) begin n_fail++; $display("FAIL frame_busy: busy dropped inside frame"); end
        rd(A_ST, s);
        n_assert++; if (s !== 32'h2) begin n_fail++; $display("FAIL frame_done_status: got %h want 00000002", s); end
    endtask

    task automatic test_overflow_back_to_back();
        logic [31:0] s; logic [7:0] b; int t0, tprev; bit good, busy_all;
        wr(A_BD, 32'd2);
        wr(A_CT, 32'd0);
        for (int i = 1; i <= 9; i++) wr(A_TX, 32'(i));
        rd(A_ST, s);
        n_assert++; if (s !== 32'h0809) begin n_fail++; $display("FAIL ovf_status: got %h want 00000809", s); end
        wr(A_CT, 32'd1);
        tprev = 0;
        for (int i = 1; i <= 8; i++) begin
            rx_frame(2, b, t0, good, busy_all);
            n_assert++;
            if (!good || b !== 8'(i)) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, b, 8'(i)); end
            if (i > 1) begin
                n_assert++;
                if (t0 - tprev !== 20) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want 20", i, t0 - tprev); end
            end
            tprev = t0;
        end
        rd(A_ST, s);
        n_assert++; if (s !== 32'h000A) begin n_fail++; $display("FAIL ovf_sticky: got %h want 0000000a", s); end
        wr(A_ST, 32'h8);
        rd(A_ST, s);
        n_assert++; if (s !== 32'h2) begin n_fail++; $display("FAIL ovf_w1c: got %h want 00000002", s); end
    endtask

    task automatic test_push_on_pop();
        logic [31:0] s; logic [7:0] b; int t0; bit good, busy_all, seen;
        logic [7:0] exp_b [9];
        exp_b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55};
        wr(A_CT, 32'd0);
        wr(A_BD, 32'd2);
        for (int i = 0; i < 8; i++) wr(A_TX, 32'h10 + 32'(i));
        wr(A_CT, 32'd1);
        wait_start(seen);
        if (!seen) return;
        wr(A_TX, 32'h18);
        repeat (18) @(negedge clk);
        rd(A_ST, s);
        n_assert++; if (s !== 32'h0805) begin n_fail++; $display("FAIL pop_pre_status: got %h want 00000805", s); end
        wr(A_TX, 32'h55);
        rd(A_ST, s);
        n_assert++; if (s !== 32'h0805) begin n_fail++; $display("FAIL pop_push_status: got %h want 00000805", s); end
        n_assert++; if (tx !== 1'b0) begin n_fail++; $display("FAIL pop_restart: tx got %b want 0", tx); end
        for (int i = 0; i < 9; i++) begin
            rx_frame(2, b, t0, good, busy_all);
            n_assert++;
            if (!good || b !== exp_b[i]) begin n_fail++; $display("FAIL pop_byte%0d: got %h want %h", i, b, exp_b[i]); end
        end
    endtask

    task automatic test_mid_frame();
        logic [31:0] s; logic [7:0] b; int t0; bit good, busy_all, seen, idle_ok;
        wr(A_CT, 32'd0);
        wr(A_BD, 32'd3);
        wr(A_TX, 32'h3C);
        wr(A_TX, 32'hC3);
        wr(A_CT, 32'd1);
        wait_start(seen);
        if (!seen) return;
        repeat (5) @(negedge clk);
        wr(A_CT, 32'd0);
        repeat (23) @(negedge clk);
        rd(A_ST, s);
        n_assert++; if (s !== 32'h0104 || tx !== 1'b1) begin n_fail++; $display("FAIL txen_stop: status %h tx %b want 00000104 1", s, tx); end
        @(negedge clk);
        rd(A_ST, s);
        n_assert++; if (s !== 32'h0100) begin n_fail++; $display("FAIL txen_done: got %h want 00000100", s); end
        idle_ok = 1'b1;
        repeat (30) begin @(negedge clk); if (tx !== 1'b1) idle_ok = 1'b0; end
        n_assert++; if (!idle_ok) begin n_fail++; $display("FAIL txen_hold: line left idle with tx_en=0"); end

        wr(A_CT, 32'd1);
        wait_start(seen);
        if (!seen) return;
        repeat (2) @(negedge clk);
        wr(A_BD, 32'd5);
        repeat (26) @(negedge clk);
        rd(A_ST, s);
        n_assert++; if (s !== 32'h0006 || tx !== 1'b1) begin n_fail++; $display("FAIL baud_old_stop: status %h tx %b want 00000006 1", s, tx); end
        @(negedge clk);
        rd(A_ST, s);
        n_assert++; if (s !== 32'h0002) begin n_fail++; $display("FAIL baud_old_end: got %h want 00000002", s); end
        wr(A_TX, 32'h5A);
        rx_frame(5, b, t0, good, busy_all);
        n_assert++; if (!good || b !== 8'h5A) begin n_fail++; $display("FAIL baud_new: got %h good=%0d want 5a", b, good); end

        wr(A_BD, 32'd0);
        rd(A_BD, s);
        n_assert++; if (s !== 32'd0) begin n_fail++; $display("FAIL baud_zero_rd: got %h want 0", s); end
        wr(A_TX, 32'h96);
        rx_frame(1, b, t0, good, busy_all);
        n_assert++; if (!good || b !== 8'h96) begin n_fail++; $display("FAIL baud_zero: got %h good=%0d want 96", b, good); end
    endtask

    task automatic test_address_edges();
        logic [31:0] s;
        wr(A_CT, 32'd0);
        wr(32'h8000_0010, 32'hAB);
        wr(32'h7FFF_FFFC, 32'h3);
        wr(32'h8000_0018, 32'h7);
        rd(32'h8000_0010, s);
        n_assert++; if (s !== 32'd0) begin n_fail++; $display("FAIL addr_rd_hi: got %h want 0", s); end
        rd(32'h7FFF_FFFC, s);
        n_assert++; if (s !== 32'd0) begin n_fail++; $display("FAIL addr_rd_lo: got %h want 0", s); end
        addr = A_BD; #1;
        n_assert++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL addr_noreq: got %h want 0", rdata); end
        rd(A_ST, s);
        n_assert++; if (s !== 32'h2) begin n_fail++; $display("FAIL addr_status: got %h want 00000002", s); end
        rd(A_CT, s);
        n_assert++; if (s !== 32'd0 || irq !== 1'b0) begin n_fail++; $display("FAIL addr_ctrl: got %h irq %b want 0 0", s, irq); end
        rd(A_BD, s);
        n_assert++; if (s !== 32'd0) begin n_fail++; $display("FAIL addr_baud: got %h want 0", s); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] s; bit seen;
        wr(A_BD, 32'd4);
        wr(A_TX, 32'h00);
        wr(A_TX, 32'h77);
        wr(A_CT, 32'd1);
        wait_start(seen);
        if (!seen) return;
        repeat (9) @(negedge clk);
        n_assert++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre: tx got %b want 0", tx); end
        rst_n = 1'b0;
        #1;
        n_assert++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_async: tx got %b want 1", tx); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(A_ST, s);
        n_assert++; if (s !== 32'h2) begin n_fail++; $display("FAIL rstmid_status: got %h want 00000002", s); end
        rd(A_BD, s);
        n_assert++; if (s !== 32'd868) begin n_fail++; $display("FAIL rstmid_baud: got %0d want 868", s); end
    endtask

    task automatic test_irq();
        wr(A_CT, 32'd3);
        n_assert++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_on: got %b want 1", irq); end
        wr(A_CT, 32'd1);
        n_assert++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_off: got %b want 0", irq); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow_back_to_back();
        test_push_on_pop();
        test_mid_frame();
        test_address_edges();
        test_reset_mid_frame();
        test_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sparrow_dmem_uart_tx.md
Name: sparrow_dmem_uart_tx

Overview:
- Memory-mapped UART transmitter slave on the core's data-memory port, downstream of the core's dmem interface.
- Decodes a 16-byte register window at BASE_ADDR and accepts bytes into a TX FIFO.
- Serialises queued bytes as 8N1 frames on o_uart_tx.
- Reads are combinational, same cycle, because the core completes loads single-cycle and has no stall input.

Parameters:
BASE_ADDR, 32'h8000_0000, byte address of the register window; must be 16-byte aligned.
FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
RESET_BAUD_DIV, 16'd868, reset value of BAUD_DIV (clocks per bit).

Ports:
i_clk  input  1  core clock
i_reset_n  input  1  asynchronous active-low reset
i_dmem_req  input  1  access valid this cycle
i_dmem_addr  input  32  byte address
i_dmem_byte_en  input  2  access size: 0 byte, 1 half, 3 word, 2 reserved (treated as word)
i_dmem_wr_en  input  1  1 write, 0 read
i_dmem_wr_data  input  32  write data, LSB-aligned
o_dmem_rd_data  output  32  read data, combinational
o_uart_tx  output  1  serial line, idle high
o_irq  output  1  level interrupt: CTRL.irq_en && FIFO empty && !busy

Behaviour:
- Clock and reset: single clock i_clk; reset is asynchronous, active-low on i_reset_n.
- Select: sel = i_dmem_req && (i_dmem_addr[31:4] == BASE_ADDR[31:4]). Register index = addr[3:2]; addr[1:0] and size are ignored for register access.
- Unselected accesses: no side effects; o_dmem_rd_data = 0.
- Register map:
  - 0x0 TXDATA: write pushes wr_data[7:0]; read returns 0.
  - 0x4 STATUS (RO except bit3): bit0 full, bit1 empty, bit2 busy (frame in progress), bit3 overflow (sticky, W1C), bits[15:8] FIFO level (0..FIFO_DEPTH); others 0.
  - 0x8 BAUD_DIV: RW [15:0]; written value 0 is stored as 0 but used as 1.
  - 0xC CTRL: RW; bit0 tx_en, bit1 irq_en.
- Write timing: writes take effect at the clock edge of the selected cycle. Reads reflect state before that edge.
- Push to a full FIFO: byte dropped, overflow set. Push and pop in the same cycle on a full FIFO: pop happens first, so the push succeeds and level is unchanged.
- FIFO: circular, pointers with an extra wrap bit; full = level==FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE->START when tx_en && !empty. On that edge: pop head into shift reg, latch effective divider into div_q, clear baud cnt and bit cnt.
  - START drives 0 for div_q clocks, then goes to DATA.
  - DATA drives shift[0], LSB first. It shifts every div_q clocks and goes to STOP after 8 bits.
  - STOP drives 1 for div_q clocks. Then it goes to START directly, with a pop, if tx_en && !empty; otherwise to IDLE. Back-to-back frames have no idle gap.
  - busy = state != IDLE.
- Frame length: exactly 10*div_q clocks, measured from the first 0 on o_uart_tx.
- Mid-frame changes:
  - Clearing tx_en mid-frame completes the current frame; no further pops.
  - A BAUD_DIV write mid-frame affects only the next frame.
- Reset values:
  - o_uart_tx=1, o_irq=0, o_dmem_rd_data=0 (no access).
  - FSM IDLE, FIFO empty, overflow=0, BAUD_DIV=RESET_BAUD_DIV, CTRL=0.
- Reset mid-frame: line returns high immediately (async); queued bytes are discarded.
- Baud counter: 16 bits, terminal at div_q-1; cannot overflow.

Test Plan:
- Reset with CTRL=0: o_uart_tx=1, o_irq=0. Read 0x8000_0004 -> 0x0000_0002; read 0x8000_0008 -> 868.
- BAUD_DIV=4, CTRL=1, write TXDATA=0xA5:
  - o_uart_tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clocks, 40 clocks total.
  - STATUS busy=1 during the frame, then STATUS=0x0002.
- BAUD_DIV=2, CTRL=0, write 9 bytes 0x01..0x09:
  - STATUS = 0x0809 (level 8, full, overflow).
  - Set CTRL=1: 8 back-to-back frames, 0x01..0x08, no idle gap.
  - Write STATUS=0x8 clears overflow.
- FIFO full, frame transmitting: at the exact STOP->START pop cycle, write TXDATA=0x55 -> accepted, level stays 8, overflow stays 0.
- Mid-frame events with BAUD_DIV=3:
  - Clear tx_en mid-frame: frame completes, the second queued byte stays, level=1.
  - BAUD_DIV write mid-frame: next frame uses the new divider.
  - BAUD_DIV=0: each bit lasts 1 clock.
- Address and reset edge cases:
  - Read or write at 0x8000_0010 and 0x7FFF_FFFC: no state change, rd_data=0.
  - Assert i_reset_n=0 mid-DATA: o_uart_tx=1 asynchronously, STATUS=0x0002 after release.
  - CTRL=3 with empty FIFO: o_irq=1.
